// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for register ALU instructions: fetches through MAR/MDR/IR,
// then emits per-step datapath strobes until done or illegal, then returns to idle.
module alu_instr_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 5,
  parameter int MEM_WAIT = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [INSTR_W-1:0]  ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] reg_out_sel,
  output logic [NUM_REGS-1:0] reg_in_sel,
  output logic [OPCODE_W-1:0] alu_op
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T4U, S_T5, S_T6
  } state_t;

  state_t state, state_nxt;

  logic [OPCODE_W-1:0] opcode;
  logic [3:0]          ra, rb, rc;
  logic                is_binary, is_muldiv, is_unary, legal;
  logic                unused_ir_bits;

  assign opcode = ir[INSTR_W-1 -: OPCODE_W];
  assign ra     = ir[INSTR_W-OPCODE_W-1 -: 4];
  assign rb     = ir[INSTR_W-OPCODE_W-5 -: 4];
  assign rc     = ir[INSTR_W-OPCODE_W-9 -: 4];
  assign unused_ir_bits = ^ir[INSTR_W-OPCODE_W-13:0];

  assign is_binary = (opcode >= OPCODE_W'(3)) && (opcode <= OPCODE_W'(10));
  assign is_muldiv = (opcode == OPCODE_W'(15)) || (opcode == OPCODE_W'(16));
  assign is_unary  = (opcode == OPCODE_W'(17)) || (opcode == OPCODE_W'(18));

  // Only fields the instruction actually uses must name an existing register.
  assign legal = (is_binary && (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS) && (32'(rc) < NUM_REGS))
              || ((is_muldiv || is_unary) && (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS));

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [3:0] idx);
    one_hot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (!(MEM_WAIT != 0 && !mem_ready)) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (!legal)        state_nxt = S_IDLE;
        else if (is_unary) state_nxt = S_T4U;
        else               state_nxt = S_T4;
      end
      S_T4:   state_nxt = S_T5;
      S_T4U:  state_nxt = S_IDLE;
      S_T5:   state_nxt = is_muldiv ? S_T6 : S_IDLE;
      S_T6:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore strobes: decoded from the state register and ir only.
  always_comb begin
    busy = (state != S_IDLE);
    done = 1'b0;   illegal = 1'b0;
    PCout = 1'b0;  MARin = 1'b0;  IncPC = 1'b0;  PCin = 1'b0;
    Read = 1'b0;   MDRin = 1'b0;  MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0;    Zin = 1'b0;    Zlowout = 1'b0; Zhighout = 1'b0;
    LOin = 1'b0;   HIin = 1'b0;
    reg_out_sel = '0;
    reg_in_sel  = '0;
    alu_op      = '0;
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (!legal) begin
          illegal = 1'b1;
        end else if (is_unary) begin
          reg_out_sel = one_hot(rb);
          alu_op      = opcode;
          Zin         = 1'b1;
        end else begin
          reg_out_sel = is_muldiv ? one_hot(ra) : one_hot(rb);
          Yin         = 1'b1;
        end
      end
      S_T4: begin
        reg_out_sel = is_muldiv ? one_hot(rb) : one_hot(rc);
        alu_op      = opcode;
        Zin         = 1'b1;
      end
      S_T4U: begin
        Zlowout    = 1'b1;
        reg_in_sel = one_hot(ra);
        done       = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          reg_in_sel = one_hot(ra);
          done       = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer with a small behavioural register/ALU datapath
// driven by the strobes, plus a second 8-register instance for field-range cases.
module tb_alu_instr_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start, start8;
  logic        mem_ready;
  logic [31:0] ir, ir8;

  logic        busy, done, illegal, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] reg_out_sel, reg_in_sel;
  logic [4:0]  alu_op;

  logic        b8_busy, b8_done, b8_illegal, b8_PCout, b8_MARin, b8_IncPC, b8_PCin, b8_Read;
  logic        b8_MDRin, b8_MDRout, b8_IRin, b8_Yin, b8_Zin, b8_Zlowout, b8_Zhighout;
  logic        b8_LOin, b8_HIin;
  logic [7:0]  b8_reg_out_sel, b8_reg_in_sel;
  logic [4:0]  b8_alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_instr_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
    .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel), .alu_op(alu_op)
  );

  alu_instr_sequencer #(.NUM_REGS(8)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .mem_ready(mem_ready), .ir(ir8),
    .busy(b8_busy), .done(b8_done), .illegal(b8_illegal),
    .PCout(b8_PCout), .MARin(b8_MARin), .IncPC(b8_IncPC), .PCin(b8_PCin), .Read(b8_Read),
    .MDRin(b8_MDRin), .MDRout(b8_MDRout), .IRin(b8_IRin),
    .Yin(b8_Yin), .Zin(b8_Zin), .Zlowout(b8_Zlowout), .Zhighout(b8_Zhighout),
    .LOin(b8_LOin), .HIin(b8_HIin),
    .reg_out_sel(b8_reg_out_sel), .reg_in_sel(b8_reg_in_sel), .alu_op(b8_alu_op)
  );

  // Behavioural datapath: a bus, Y, 64-bit Z, LO/HI and sixteen registers.
  logic [31:0] regs [16];
  logic [31:0] y_reg, lo_reg, hi_reg, bus;
  logic [63:0] z_reg;

  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'd5:    alu_model = {32'h0, a & b};
      5'd15:   alu_model = {32'h0, a} * {32'h0, b};
      5'd17:   alu_model = {32'h0, -b};
      default: alu_model = 64'h0;
    endcase
  endfunction

  always_comb begin
    bus = 32'h0;
    for (int i = 0; i < 16; i++) if (reg_out_sel[i]) bus = regs[i];
    if (Zlowout)  bus = z_reg[31:0];
    if (Zhighout) bus = z_reg[63:32];
  end

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
      regs[2] <= 32'h12;
      regs[3] <= 32'h14;
      regs[4] <= 32'h3;
      regs[5] <= 32'h5;
      y_reg <= 32'h0; z_reg <= 64'h0; lo_reg <= 32'h0; hi_reg <= 32'h0;
    end else begin
      if (Yin)  y_reg  <= bus;
      if (Zin)  z_reg  <= alu_model(alu_op, y_reg, bus);
      if (LOin) lo_reg <= bus;
      if (HIin) hi_reg <= bus;
      for (int i = 0; i < 16; i++) if (reg_in_sel[i]) regs[i] <= bus;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Pulses start on the main instance; returns mid-cycle of cycle 1 (T0).
  task automatic applyStimulus(input logic [31:0] instr);
    @(negedge clock);
    ir    = instr;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic start_dut8(input logic [31:0] instr);
    @(negedge clock);
    ir8    = instr;
    start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; start8 = 1'b0; mem_ready = 1'b1; ir = 32'h0; ir8 = 32'h0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_strobes", {PCout, Zin, Read, Yin, done, illegal}, 0);
    checkOutput("reset_sel", {reg_out_sel, reg_in_sel, alu_op}, 0);
    @(negedge clock);
    clear = 1'b0;

    $display("[TB] case 1: and R1,R2,R3");
    applyStimulus(32'h28918000);
    checkOutput("c1_t0", {busy, PCout, MARin, IncPC, Zin}, 5'b11111);
    step();
    checkOutput("c1_t1", {Zlowout, PCin, Read, MDRin}, 4'b1111);
    step();
    checkOutput("c1_t2", {MDRout, IRin}, 2'b11);
    step();
    checkOutput("c1_t3_sel", reg_out_sel, 16'h0004);
    checkOutput("c1_t3_yin", Yin, 1);
    step();
    checkOutput("c1_t4_sel", reg_out_sel, 16'h0008);
    checkOutput("c1_t4_op", {alu_op, Zin}, {5'd5, 1'b1});
    checkOutput("c1_t4_nodone", done, 0);
    step();
    checkOutput("c1_t5_in", reg_in_sel, 16'h0002);
    checkOutput("c1_t5_done", {done, Zlowout}, 2'b11);
    step();
    checkOutput("c1_idle", {busy, done}, 2'b00);
    checkOutput("c1_r1", regs[1], 32'h10);

    $display("[TB] case 2: memory wait");
    pulse_clear();
    mem_ready = 1'b0;
    applyStimulus(32'h28918000);
    for (int c = 2; c <= 5; c++) begin
      step();
      checkOutput($sformatf("c2_t1_hold_%0d", c), {Read, MDRin}, 2'b11);
      if (c == 5) mem_ready = 1'b1;
    end
    step(); step(); step();
    checkOutput("c2_c8_nodone", done, 0);
    step();
    checkOutput("c2_c9_done", {done, reg_in_sel}, {1'b1, 16'h0002});
    step();
    checkOutput("c2_r1", regs[1], 32'h10);

    $display("[TB] case 3: mul R4,R5");
    pulse_clear();
    applyStimulus(32'h7A280000);
    step(); step(); step();
    checkOutput("c3_t3_sel", {reg_out_sel, Yin}, {16'h0010, 1'b1});
    step();
    checkOutput("c3_t4_sel", {reg_out_sel, alu_op, Zin}, {16'h0020, 5'd15, 1'b1});
    step();
    checkOutput("c3_t5", {LOin, Zlowout, done, reg_in_sel}, {3'b110, 16'h0});
    step();
    checkOutput("c3_t6", {HIin, Zhighout, done, reg_in_sel}, {3'b111, 16'h0});
    step();
    checkOutput("c3_lohi", {busy, hi_reg, lo_reg}, {1'b0, 32'h0, 32'hF});

    $display("[TB] case 4: illegal opcode");
    applyStimulus(32'hF8000000);
    step(); step(); step();
    checkOutput("c4_t3", {illegal, done, Yin, Zin}, 4'b1000);
    checkOutput("c4_t3_sel", {reg_out_sel, reg_in_sel}, 32'h0);
    step();
    checkOutput("c4_after", {busy, illegal, done}, 3'b000);

    $display("[TB] case 5: NUM_REGS=8");
    start_dut8(32'h28948000);
    step(); step(); step();
    checkOutput("c5_rc9_illegal", {b8_illegal, b8_done, b8_reg_out_sel}, {2'b10, 8'h0});
    step();
    checkOutput("c5_rc9_idle", b8_busy, 0);
    start_dut8(32'h8B380000);
    step(); step(); step();
    checkOutput("c5_neg_t3", {b8_reg_out_sel, b8_alu_op, b8_Zin, b8_Yin}, {8'h80, 5'd17, 2'b10});
    step();
    checkOutput("c5_neg_t4u", {b8_done, b8_Zlowout, b8_reg_in_sel}, {2'b11, 8'h40});
    step();
    checkOutput("c5_neg_idle", {b8_busy, b8_done}, 2'b00);

    $display("[TB] case 6: clear during T4");
    pulse_clear();
    applyStimulus(32'h28918000);
    step(); step(); step(); step();
    checkOutput("c6_in_t4", Zin, 1);
    clear = 1'b1;
    #1;
    checkOutput("c6_clear_out", {busy, Zin, alu_op, reg_out_sel}, 0);
    step();
    clear = 1'b0;
    step();
    checkOutput("c6_no_done", {busy, done, reg_in_sel}, 0);
    checkOutput("c6_r1_untouched", regs[1], 32'h0);
    applyStimulus(32'h28918000);
    step(); step(); step(); step();
    checkOutput("c6_c5_nodone", done, 0);
    step();
    checkOutput("c6_c6_done", {done, reg_in_sel}, {1'b1, 16'h0002});
    step();
    checkOutput("c6_r1", regs[1], 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
